// File: rtl/square_seq.sv
// ============================================================================
// Module  : square_seq
// Purpose : Sequential shift-add squarer, Q = X*X saturated to C_OW bits,
//           with a delay tag advanced by the fixed result latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module square_seq #(
    parameter int C_W   = 12,
    parameter int C_OW  = 23,
    parameter int C_RDX = 1
) (
    input  logic             CK_i,
    input  logic             XARST_i,
    input  logic             STB_i,
    input  logic [C_W-1:0]   DATs_i,
    input  logic [7:0]       B_IN_DAT_DLYs_i,
    output logic             RDY_o,
    output logic             VLD_o,
    output logic [C_OW-1:0]  QQs_o,
    output logic             SAT_o,
    output logic             DROP_o,
    output logic [7:0]       B_OUT_DAT_DLYs_o
);

    localparam int N  = C_W / C_RDX;
    localparam int AW = 2 * C_W;
    localparam int MW = C_W + C_RDX;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = (C_W > 1) ? $clog2(C_W) : 1;
    localparam int SW = $clog2(AW);
    localparam logic [7:0]    LAT  = 8'(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [C_W-1:0]  x_reg;
    logic [7:0]      tag_reg;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [XW-1:0]    dig_lsb;
    logic [SW-1:0]    shift_amt;
    logic [C_RDX-1:0] digit;
    logic [MW-1:0]    mul;
    logic [AW-1:0]    partial;
    logic [AW-1:0]    acc_next;
    logic             sat_next;

    // One radix-2^C_RDX digit of X per cycle, weighted by its bit position.
    assign dig_lsb   = XW'(cnt) * XW'(C_RDX);
    assign shift_amt = SW'(dig_lsb);
    assign digit     = x_reg[dig_lsb +: C_RDX];
    assign mul       = MW'(x_reg) * MW'(digit);
    assign partial   = AW'(mul) << shift_amt;
    assign acc_next  = acc + partial;
    assign sat_next  = (acc_next >> C_OW) != '0;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state            <= S_IDLE;
            RDY_o            <= 1'b1;
            VLD_o            <= 1'b0;
            QQs_o            <= '0;
            SAT_o            <= 1'b0;
            DROP_o           <= 1'b0;
            B_OUT_DAT_DLYs_o <= '0;
            x_reg            <= '0;
            tag_reg          <= '0;
            acc              <= '0;
            cnt              <= '0;
        end else begin
            VLD_o  <= 1'b0;
            DROP_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (STB_i) begin
                        x_reg   <= DATs_i;
                        tag_reg <= B_IN_DAT_DLYs_i;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= S_CALC;
                        RDY_o   <= 1'b0;
                    end else begin
                        state   <= S_IDLE;
                        RDY_o   <= 1'b1;
                    end
                end
                S_CALC: begin
                    // Strobes arriving mid-computation are lost, only flagged.
                    DROP_o <= STB_i;
                    acc    <= acc_next;
                    if (cnt == LAST) begin
                        state            <= S_DONE;
                        RDY_o            <= 1'b1;
                        VLD_o            <= 1'b1;
                        QQs_o            <= sat_next ? {C_OW{1'b1}} : acc_next[C_OW-1:0];
                        SAT_o            <= sat_next;
                        B_OUT_DAT_DLYs_o <= tag_reg + LAT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    RDY_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_square_seq.sv
// Bench for square_seq: four radix variants share one stimulus stream and are
// scored against an arithmetic model of the accept/latency/drop rules.
`default_nettype none

module tb_square_seq;

    localparam int NI = 4;

    typedef struct {
        logic [22:0] q;
        logic        sat;
        logic [7:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic [11:0] x;
    logic [7:0]  tag;

    logic [NI-1:0] vld_a, rdy_a, sat_a, drop_a;
    logic [22:0]   qq_a  [NI];
    logic [7:0]    tago_a[NI];

    exp_t sb[NI][$];
    int   rem[NI];
    logic [NI-1:0] e_vld, e_drop, e_rdy;
    logic chk_rst, end_chk;

    int n_chk, n_fail;

    function automatic int rdx_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 4 : 12;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        square_seq #(.C_W(12), .C_OW(23), .C_RDX(rdx_of(g))) u_dut (
            .CK_i             (clk),
            .XARST_i          (rst_n),
            .STB_i            (stb),
            .DATs_i           (x),
            .B_IN_DAT_DLYs_i  (tag),
            .RDY_o            (rdy_a[g]),
            .VLD_o            (vld_a[g]),
            .QQs_o            (qq_a[g]),
            .SAT_o            (sat_a[g]),
            .DROP_o           (drop_a[g]),
            .B_OUT_DAT_DLYs_o (tago_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            rem[i] = 0;
            sb[i].delete();
        end
        e_vld  = '0;
        e_drop = '0;
        e_rdy  = '1;
    endfunction

    // Reference model: per-edge view of what each instance must do.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            int n;
            n = 12 / rdx_of(i);
            e_vld[i]  = 1'b0;
            e_drop[i] = 1'b0;
            if (!rst_n) begin
                rem[i] = 0;
                sb[i].delete();
            end else if (rem[i] > 0) begin
                e_drop[i] = stb;
                e_vld[i]  = (rem[i] == 1);
                rem[i]--;
            end else if (stb) begin
                exp_t   e;
                longint p;
                p     = longint'(x) * longint'(x);
                e.sat = (p >= 64'd8388608);
                e.q   = e.sat ? 23'h7FFFFF : p[22:0];
                e.tag = 8'(int'(tag) + n + 1);
                sb[i].push_back(e);
                rem[i] = n;
            end
            e_rdy[i] = (rem[i] == 0);
        end
        #1;
    endtask

    task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst %0d] t=%0t: got %0d expected %0d", nm, inst, $time, act, exp);
        end
    endtask

    // Monitor: compares handshake pulses every cycle and pops results on VLD.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("vld",  i, 32'(vld_a[i]),  32'(e_vld[i]));
            chk("drop", i, 32'(drop_a[i]), 32'(e_drop[i]));
            chk("rdy",  i, 32'(rdy_a[i]),  32'(e_rdy[i]));
            if (vld_a[i] === 1'b1) begin
                chk("sb_has_entry", i, 32'(sb[i].size() > 0), 32'd1);
                if (sb[i].size() > 0) begin
                    exp_t e;
                    e = sb[i].pop_front();
                    chk("qq",  i, 32'(qq_a[i]),   32'(e.q));
                    chk("sat", i, 32'(sat_a[i]),  32'(e.sat));
                    chk("tag", i, 32'(tago_a[i]), 32'(e.tag));
                end
            end
            if (chk_rst) begin
                chk("rst_qq",  i, 32'(qq_a[i]),   32'd0);
                chk("rst_sat", i, 32'(sat_a[i]),  32'd0);
                chk("rst_tag", i, 32'(tago_a[i]), 32'd0);
            end
            if (end_chk) chk("sb_drained", i, 32'(sb[i].size()), 32'd0);
        end
    end

    task automatic idle(int n);
        stb = 1'b0;
        repeat (n) tick();
    endtask

    task automatic issue(logic [11:0] xv, logic [7:0] tv);
        stb = 1'b1;
        x   = xv;
        tag = tv;
        tick();
        stb = 1'b0;
    endtask

    initial begin
        int k;
        n_chk   = 0;
        n_fail  = 0;
        chk_rst = 1'b1;
        end_chk = 1'b0;
        rst_n   = 1'b0;
        stb     = 1'b0;
        x       = '0;
        tag     = '0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_rst = 1'b0;

        // Zero operand, zero tag
        issue(12'd0, 8'd0);
        idle(15);

        // Saturation boundary
        issue(12'd2896, 8'd10);  idle(14);
        issue(12'd2897, 8'd250); idle(14);
        issue(12'd4095, 8'd255); idle(14);

        // Strobe held high; operand advances only when the radix-1 unit is ready
        k   = 1;
        stb = 1'b1;
        for (int c = 0; c < 6 * 13; c++) begin
            if (rem[0] == 0) begin
                x   = 12'(k);
                tag = 8'(k * 3);
                k++;
            end
            tick();
        end
        idle(15);

        // Strobe during computation is dropped
        issue(12'd100, 8'd1);
        idle(2);
        issue(12'd7, 8'd2);
        idle(15);

        // Reset pulse mid-computation
        issue(12'd999, 8'd9);
        idle(4);
        rst_n   = 1'b0;
        model_reset();
        chk_rst = 1'b1;
        tick();
        rst_n = 1'b1;
        idle(15);
        chk_rst = 1'b0;
        issue(12'd5, 8'd5);
        idle(15);

        // Random sweep with corner operands mixed in
        for (int c = 0; c < 40000; c++) begin
            int sel;
            stb = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 7);
            x   = (sel == 0) ? 12'd0 : (sel == 1) ? 12'hFFF : 12'($urandom);
            tag = 8'($urandom);
            tick();
        end
        idle(20);

        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
